// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the single-SRAM access arbiter and its requesters.
// FSM encodings are plain localparams so they can be dropped into legacy state registers.
package sram_arb_pkg;

    localparam int SRAM_ADDR_W = 20;
    localparam int SRAM_DATA_W = 16;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RD      = 2'd1;
    localparam logic [1:0] ST_WR      = 2'd2;
    localparam logic [1:0] ST_WR_HOLD = 2'd3;

    typedef struct packed {
        logic                   we;
        logic [SRAM_ADDR_W-1:0] addr;
        logic [SRAM_DATA_W-1:0] wdata;
        logic [1:0]             be;
    } sram_req_t;

endpackage

// File: rtl/sram_arb_select.sv
// Two-port priority select: port 0 preferred, port 1 forced through after STARVE_MAX port-0 wins.
// Zero-cycle combinational grant, only while the sequencer reports idle; losers simply keep requesting.
module sram_arb_select
    import sram_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_idle,
    input  logic       i_req0,
    input  logic       i_req1,
    output logic [1:0] o_gnt,
    output logic       o_sel
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starve_cnt;

    always_comb begin
        o_sel = i_req1 && (!i_req0 || (starve_cnt == CNT_MAX));
        o_gnt = 2'b00;
        if (i_idle && (i_req0 || i_req1)) begin
            o_gnt = o_sel ? 2'b10 : 2'b01;
        end
    end

    // Counts port-0 wins only while port 1 is actually waiting.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            starve_cnt <= '0;
        end else if (!i_req1 || o_gnt[1]) begin
            starve_cnt <= '0;
        end else if (o_gnt[0] && (starve_cnt != CNT_MAX)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sram_access_arbiter.sv
// Shares one async 16-bit SRAM between pixel fetch (port 0) and game logic (port 1); all pins registered.
// Read data returns RD_WAIT+1 cycles after grant; requests stall (held by the requester) until granted in IDLE.
module sram_access_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W     = SRAM_ADDR_W,
    parameter int DATA_W     = SRAM_DATA_W,
    parameter int RD_WAIT    = 1,
    parameter int WR_WAIT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req0,
    input  logic              i_req1,
    input  logic              i_we0,
    input  logic              i_we1,
    input  logic [ADDR_W-1:0] i_addr0,
    input  logic [ADDR_W-1:0] i_addr1,
    input  logic [DATA_W-1:0] i_wdata0,
    input  logic [DATA_W-1:0] i_wdata1,
    input  logic [1:0]        i_be0,
    input  logic [1:0]        i_be1,
    output logic              o_gnt0,
    output logic              o_gnt1,
    output logic              o_rvalid0,
    output logic              o_rvalid1,
    output logic [DATA_W-1:0] o_rdata,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic [DATA_W-1:0] o_sram_dq,
    output logic              o_sram_dq_oe,
    input  logic [DATA_W-1:0] i_sram_dq,
    output logic              o_sram_ce_n,
    output logic              o_sram_oe_n,
    output logic              o_sram_we_n,
    output logic              o_sram_lb_n,
    output logic              o_sram_ub_n
);

    localparam int WAIT_MAX = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
    localparam int WAIT_W   = $clog2(WAIT_MAX + 1);
    localparam logic [WAIT_W-1:0] RD_LAST = WAIT_W'(RD_WAIT - 1);
    localparam logic [WAIT_W-1:0] WR_LAST = WAIT_W'(WR_WAIT - 1);

    logic [1:0]        state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              own_port;
    logic [1:0]        gnt;
    logic              sel;

    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [1:0]        sel_be;

    sram_arb_select #(
        .STARVE_MAX (STARVE_MAX)
    ) u_select (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_idle (state == ST_IDLE),
        .i_req0 (i_req0),
        .i_req1 (i_req1),
        .o_gnt  (gnt),
        .o_sel  (sel)
    );

    assign o_gnt0 = gnt[0];
    assign o_gnt1 = gnt[1];

    always_comb begin
        sel_we    = sel ? i_we1    : i_we0;
        sel_addr  = sel ? i_addr1  : i_addr0;
        sel_wdata = sel ? i_wdata1 : i_wdata0;
        sel_be    = sel ? i_be1    : i_be0;
    end

    // The pin registers double as the latched request: address, data and lanes are captured at grant.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= ST_IDLE;
            wait_cnt     <= '0;
            own_port     <= 1'b0;
            o_sram_ce_n  <= 1'b1;
            o_sram_oe_n  <= 1'b1;
            o_sram_we_n  <= 1'b1;
            o_sram_lb_n  <= 1'b1;
            o_sram_ub_n  <= 1'b1;
            o_sram_dq_oe <= 1'b0;
            o_sram_addr  <= '0;
            o_sram_dq    <= '0;
            o_rdata      <= '0;
            o_rvalid0    <= 1'b0;
            o_rvalid1    <= 1'b0;
        end else begin
            o_rvalid0 <= 1'b0;
            o_rvalid1 <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (|gnt) begin
                        own_port    <= sel;
                        wait_cnt    <= '0;
                        o_sram_addr <= sel_addr;
                        o_sram_ce_n <= 1'b0;
                        o_sram_lb_n <= ~sel_be[0];
                        o_sram_ub_n <= ~sel_be[1];
                        if (sel_we) begin
                            o_sram_we_n  <= 1'b0;
                            o_sram_oe_n  <= 1'b1;
                            o_sram_dq_oe <= 1'b1;
                            o_sram_dq    <= sel_wdata;
                            state        <= ST_WR;
                        end else begin
                            o_sram_we_n  <= 1'b1;
                            o_sram_oe_n  <= 1'b0;
                            o_sram_dq_oe <= 1'b0;
                            state        <= ST_RD;
                        end
                    end
                end
                ST_RD: begin
                    if (wait_cnt == RD_LAST) begin
                        o_rdata     <= i_sram_dq;
                        o_rvalid0   <= ~own_port;
                        o_rvalid1   <= own_port;
                        o_sram_ce_n <= 1'b1;
                        o_sram_oe_n <= 1'b1;
                        o_sram_lb_n <= 1'b1;
                        o_sram_ub_n <= 1'b1;
                        state       <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_WR: begin
                    if (wait_cnt == WR_LAST) begin
                        o_sram_we_n <= 1'b1;
                        state       <= ST_WR_HOLD;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_WR_HOLD: begin
                    // Releasing DQ here leaves one idle cycle before any read can drive OE.
                    o_sram_ce_n  <= 1'b1;
                    o_sram_lb_n  <= 1'b1;
                    o_sram_ub_n  <= 1'b1;
                    o_sram_dq_oe <= 1'b0;
                    state        <= ST_IDLE;
                end
                default: begin
                    o_sram_ce_n  <= 1'b1;
                    o_sram_oe_n  <= 1'b1;
                    o_sram_we_n  <= 1'b1;
                    o_sram_lb_n  <= 1'b1;
                    o_sram_ub_n  <= 1'b1;
                    o_sram_dq_oe <= 1'b0;
                    state        <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Bench for sram_access_arbiter: behavioural SRAM, read scoreboard, vector table plus corner sequences.
module tb_sram_access_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1, we0, we1;
    logic [19:0] addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic [1:0]  be0, be1;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [15:0] rdata;
    logic [19:0] sram_addr;
    logic [15:0] sram_dq_out, sram_dq_in;
    logic        sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n;

    always #5 clk = ~clk;

    sram_access_arbiter dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req0       (req0),
        .i_req1       (req1),
        .i_we0        (we0),
        .i_we1        (we1),
        .i_addr0      (addr0),
        .i_addr1      (addr1),
        .i_wdata0     (wdata0),
        .i_wdata1     (wdata1),
        .i_be0        (be0),
        .i_be1        (be1),
        .o_gnt0       (gnt0),
        .o_gnt1       (gnt1),
        .o_rvalid0    (rvalid0),
        .o_rvalid1    (rvalid1),
        .o_rdata      (rdata),
        .o_sram_addr  (sram_addr),
        .o_sram_dq    (sram_dq_out),
        .o_sram_dq_oe (sram_dq_oe),
        .i_sram_dq    (sram_dq_in),
        .o_sram_ce_n  (sram_ce_n),
        .o_sram_oe_n  (sram_oe_n),
        .o_sram_we_n  (sram_we_n),
        .o_sram_lb_n  (sram_lb_n),
        .o_sram_ub_n  (sram_ub_n)
    );

    // Behavioural SRAM: 1K words, byte-lane writes while WE is low, DEAD on the bus when not reading.
    logic [15:0] mem [0:1023];
    logic        mem_init = 1'b0;

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 16'h0000;
            mem[10'h123] <= 16'hBEEF;
            mem_init <= 1'b1;
        end else if (!sram_ce_n && !sram_we_n && sram_dq_oe) begin
            if (!sram_lb_n) mem[sram_addr[9:0]][7:0]  <= sram_dq_out[7:0];
            if (!sram_ub_n) mem[sram_addr[9:0]][15:8] <= sram_dq_out[15:8];
        end
    end

    assign sram_dq_in = (!sram_ce_n && !sram_oe_n && !sram_dq_oe) ? mem[sram_addr[9:0]] : 16'hDEAD;

    typedef struct {
        logic        port;
        logic [15:0] data;
        logic        chk;
    } sb_t;

    typedef struct {
        logic        port;
        logic        we;
        logic [19:0] addr;
        logic [15:0] wdata;
        logic [1:0]  be;
        logic [15:0] exp;
        logic        chk;
    } vec_t;

    sb_t  sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Runs for the whole test: single-grant rule and read-data scoreboard.
    task automatic monitor();
        sb_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (gnt0 || gnt1) check("single_gnt", {31'b0, gnt0 & gnt1}, 32'd0);
                if (rvalid0 || rvalid1) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_rvalid: got rvalid0=%b rvalid1=%b expected none", rvalid0, rvalid1);
                    end else begin
                        e = sb.pop_front();
                        check("rvalid_port", {30'b0, rvalid1, rvalid0}, e.port ? 32'd2 : 32'd1);
                        if (e.chk) check("rdata", {16'b0, rdata}, {16'b0, e.data});
                    end
                end
            end
        end
    endtask

    task automatic drive(input logic port, input logic we, input logic [19:0] addr,
                         input logic [15:0] wdata, input logic [1:0] be);
        if (port) begin
            we1 = we; addr1 = addr; wdata1 = wdata; be1 = be; req1 = 1'b1;
        end else begin
            we0 = we; addr0 = addr; wdata0 = wdata; be0 = be; req0 = 1'b1;
        end
    endtask

    task automatic do_access(input logic port, input logic we, input logic [19:0] addr,
                             input logic [15:0] wdata, input logic [1:0] be,
                             input logic [15:0] exp, input logic chk);
        bit got = 0;
        drive(port, we, addr, wdata, be);
        for (int n = 0; n < 50 && !got; n++) begin
            @(negedge clk);
            if (port ? gnt1 : gnt0) got = 1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL gnt_timeout: got no grant for port %0d expected one within 50 cycles", port);
        end else if (!we) begin
            sb.push_back(sb_t'{port, exp, chk});
        end
        @(posedge clk);
        #1;
        if (port) req1 = 1'b0; else req0 = 1'b0;
    endtask

    function automatic logic [9:0] pins();
        return {sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n, sram_dq_oe,
                gnt0, gnt1, rvalid0, rvalid1};
    endfunction

    localparam int NV = 10;
    vec_t vec [NV];

    initial begin
        #400000;
        $display("FAIL watchdog: got no end of test expected finish before 400us");
        $fatal(1);
    end

    initial begin
        logic gpat [10];
        int   ng;
        bit   saw_gap, saw_wr, oe_fell, granted;

        vec[0] = '{1'b1, 1'b1, 20'h00040, 16'hA5C3, 2'b11, 16'h0000, 1'b0};
        vec[1] = '{1'b0, 1'b1, 20'h00040, 16'hFF00, 2'b10, 16'h0000, 1'b0};
        vec[2] = '{1'b0, 1'b0, 20'h00040, 16'h0000, 2'b11, 16'hFFC3, 1'b1};
        vec[3] = '{1'b1, 1'b0, 20'h00040, 16'h0000, 2'b11, 16'hFFC3, 1'b1};
        vec[4] = '{1'b1, 1'b1, 20'h00041, 16'h0102, 2'b11, 16'h0000, 1'b0};
        vec[5] = '{1'b0, 1'b0, 20'h00041, 16'h0000, 2'b11, 16'h0102, 1'b1};
        vec[6] = '{1'b1, 1'b0, 20'h00123, 16'h0000, 2'b00, 16'h0000, 1'b0};
        vec[7] = '{1'b0, 1'b1, 20'h00041, 16'hEEEE, 2'b00, 16'h0000, 1'b0};
        vec[8] = '{1'b1, 1'b0, 20'h00041, 16'h0000, 2'b11, 16'h0102, 1'b1};
        vec[9] = '{1'b0, 1'b0, 20'h00010, 16'h0000, 2'b01, 16'h0034, 1'b1};

        rst = 1'b1;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; be0 = '0; be1 = '0;
        fork
            monitor();
        join_none

        // Reset state, then ten idle cycles.
        repeat (3) @(posedge clk);
        #1;
        check("rst_pins", {22'b0, pins()}, 32'h3E0);
        check("rst_addr", {12'b0, sram_addr}, 32'd0);
        check("rst_rdata", {16'b0, rdata}, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_pins", {22'b0, pins()}, 32'h3E0);
        end

        // Port-0 read latency: gnt at t, strobes at t+1, rvalid at t+2.
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 20'h00123, 16'h0000, 2'b11);
        @(negedge clk);
        check("lat_gnt0", {31'b0, gnt0}, 32'd1);
        sb.push_back(sb_t'{1'b0, 16'hBEEF, 1'b1});
        @(posedge clk);
        #1;
        req0 = 1'b0;
        @(negedge clk);
        check("lat_rd_strobes", {22'b0, pins()}, 10'b0010000000);
        check("lat_rd_addr", {12'b0, sram_addr}, 32'h00123);
        @(negedge clk);
        check("lat_rvalid0", {31'b0, rvalid0}, 32'd1);
        check("lat_rdata", {16'b0, rdata}, 32'hBEEF);

        // Port-1 low-byte write: WR, WR_HOLD, then idle with DQ released.
        @(posedge clk);
        #1;
        drive(1'b1, 1'b1, 20'h00010, 16'h1234, 2'b01);
        @(negedge clk);
        check("wr_gnt1", {31'b0, gnt1}, 32'd1);
        @(posedge clk);
        #1;
        req1 = 1'b0;
        @(negedge clk);
        check("wr_strobes", {22'b0, pins()}, 10'b0100110000);
        check("wr_dq", {16'b0, sram_dq_out}, 32'h1234);
        @(negedge clk);
        check("wr_hold_strobes", {22'b0, pins()}, 10'b0110110000);
        @(negedge clk);
        check("wr_idle_strobes", {22'b0, pins()}, 10'b1111100000);
        check("wr_mem_word", {16'b0, mem[10'h010]}, 32'h0034);

        // Both ports requesting continuously: 0,0,0,0,1 repeating.
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 20'h00123, 16'h0000, 2'b11);
        drive(1'b1, 1'b0, 20'h00010, 16'h0000, 2'b11);
        ng = 0;
        for (int c = 0; c < 100 && ng < 10; c++) begin
            @(negedge clk);
            if (gnt0 || gnt1) begin
                gpat[ng] = gnt1;
                sb.push_back(sb_t'{gnt1, gnt1 ? 16'h0034 : 16'hBEEF, 1'b1});
                ng++;
            end
        end
        @(posedge clk);
        #1;
        req0 = 1'b0;
        req1 = 1'b0;
        check("starve_grant_count", ng, 32'd10);
        for (int i = 0; i < ng; i++) check("starve_pattern", {31'b0, gpat[i]}, (i % 5 == 4) ? 32'd1 : 32'd0);
        repeat (3) @(negedge clk);

        // Write then read: an idle, undriven bus cycle before OE falls.
        @(posedge clk);
        #1;
        drive(1'b1, 1'b1, 20'h00030, 16'h5678, 2'b11);
        @(negedge clk);
        check("ta_gnt1", {31'b0, gnt1}, 32'd1);
        @(posedge clk);
        #1;
        req1 = 1'b0;
        drive(1'b0, 1'b0, 20'h00030, 16'h0000, 2'b11);
        saw_gap = 0; saw_wr = 0; oe_fell = 0; granted = 0;
        for (int c = 0; c < 20 && !oe_fell; c++) begin
            @(negedge clk);
            if (gnt0 && !granted) begin
                granted = 1;
                sb.push_back(sb_t'{1'b0, 16'h5678, 1'b1});
            end
            if (!sram_oe_n) begin
                oe_fell = 1;
                check("ta_no_drive_on_read", {31'b0, sram_dq_oe}, 32'd0);
            end else if (saw_wr && !sram_dq_oe && sram_we_n) begin
                saw_gap = 1;
            end
            if (!sram_we_n) saw_wr = 1;
            @(posedge clk);
            #1;
            if (granted) req0 = 1'b0;
        end
        req0 = 1'b0;
        check("ta_oe_fell", {31'b0, oe_fell}, 32'd1);
        check("ta_gap", {31'b0, saw_gap}, 32'd1);
        repeat (3) @(negedge clk);

        // Reset in the middle of a read: abort, no rvalid afterwards, then a normal read.
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 20'h00123, 16'h0000, 2'b11);
        @(negedge clk);
        check("rr_gnt0", {31'b0, gnt0}, 32'd1);
        @(posedge clk);
        #1;
        req0 = 1'b0;
        check("rr_in_rd", {31'b0, sram_oe_n}, 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check("rr_async_pins", {22'b0, pins()}, 32'h3E0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("rr_idle_after", {22'b0, pins()}, 32'h3E0);
        @(posedge clk);
        #1;
        do_access(1'b0, 1'b0, 20'h00010, 16'h0000, 2'b11, 16'h0034, 1'b1);

        // Vector table.
        for (int i = 0; i < NV; i++) begin
            do_access(vec[i].port, vec[i].we, vec[i].addr, vec[i].wdata, vec[i].be, vec[i].exp, vec[i].chk);
        end

        repeat (10) @(negedge clk);
        check("sb_drain", sb.size(), 32'd0);
        check("final_mem_41", {16'b0, mem[10'h041]}, 32'h0102);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
